// File: rtl/rtc_time_ctrl_pkg.sv
// Shared constants, field widths and FSM encoding for the RTC
// time controller and its mod-N counters.
package rtc_pkg;

    localparam int SEC_W_DEF  = 6;
    localparam int MIN_W_DEF  = 6;
    localparam int HOUR_W_DEF = 5;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } rtc_state_e;

endpackage

// File: rtl/rtc_time_ctrl_if.sv
// Host time-set handshake: set_valid/set_ready plus the h:m:s load value.
// master = host side, slave = controller side.
interface rtc_time_ctrl_if #(
    parameter int SEC_W  = 6,
    parameter int MIN_W  = 6,
    parameter int HOUR_W = 5
) ();

    logic              set_valid;
    logic              set_ready;
    logic [SEC_W-1:0]  set_sec;
    logic [MIN_W-1:0]  set_min;
    logic [HOUR_W-1:0] set_hour;

    modport master (
        output set_valid,
        output set_sec,
        output set_min,
        output set_hour,
        input  set_ready
    );

    modport slave (
        input  set_valid,
        input  set_sec,
        input  set_min,
        input  set_hour,
        output set_ready
    );

endinterface

// File: rtl/rtc_mod_counter.sv
// Mod-(MAX+1) counter with synchronous load.
// Ports: clk, rst, inc, cin (carry-in gate), load, load_val -> value, carry_out.
module rtc_mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         cin,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry_out
);

    logic step;
    logic at_max;

    assign step      = inc && cin;
    assign at_max    = (value == W'(MAX));
    assign carry_out = at_max && step;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (step) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/rtc_time_ctrl.sv
// RTC timekeeping: tick edge detect, STOP/RUN/LOAD FSM, host load with range check.
// Ports: clk, rst, tick, run_en, set_if (slave) -> sec, min, hour, running, day_pulse, set_err.
module rtc_time_ctrl
    import rtc_pkg::*;
#(
    parameter int SEC_W  = SEC_W_DEF,
    parameter int MIN_W  = MIN_W_DEF,
    parameter int HOUR_W = HOUR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              run_en,
    rtc_time_ctrl_if.slave    set_if,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              running,
    output logic              day_pulse,
    output logic              set_err
);

    rtc_state_e state;
    logic       tick_prev;
    logic       tick_rise;
    logic       accept;
    logic       fields_ok;
    logic       load_ok;
    logic       adv;
    logic       sec_co;
    logic       min_co;
    logic       hour_co;

    assign tick_rise = tick && !tick_prev;

    assign set_if.set_ready = !rst && (state != LOAD);

    assign accept = set_if.set_valid && set_if.set_ready;

    assign fields_ok = (set_if.set_sec  <= SEC_W'(SEC_MAX))
                    && (set_if.set_min  <= MIN_W'(MIN_MAX))
                    && (set_if.set_hour <= HOUR_W'(HOUR_MAX));

    assign load_ok = accept && fields_ok;

    // Any accept cycle (good or rejected) drops a coincident tick,
    // so a rejected load leaves the time untouched.
    assign adv = (state == RUN) && tick_rise && !accept;

    rtc_mod_counter #(
        .W   (SEC_W),
        .MAX (SEC_MAX)
    ) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (adv),
        .cin       (1'b1),
        .load      (load_ok),
        .load_val  (set_if.set_sec),
        .value     (sec),
        .carry_out (sec_co)
    );

    rtc_mod_counter #(
        .W   (MIN_W),
        .MAX (MIN_MAX)
    ) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (adv),
        .cin       (sec_co),
        .load      (load_ok),
        .load_val  (set_if.set_min),
        .value     (min),
        .carry_out (min_co)
    );

    rtc_mod_counter #(
        .W   (HOUR_W),
        .MAX (HOUR_MAX)
    ) u_hour (
        .clk       (clk),
        .rst       (rst),
        .inc       (adv),
        .cin       (min_co),
        .load      (load_ok),
        .load_val  (set_if.set_hour),
        .value     (hour),
        .carry_out (hour_co)
    );

    // tick_prev resets high so a tick held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STOP;
            tick_prev <= 1'b1;
            running   <= 1'b0;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            tick_prev <= tick;
            day_pulse <= hour_co;
            set_err   <= accept && !fields_ok;
            unique case (state)
                STOP, RUN: begin
                    if (load_ok) begin
                        state   <= LOAD;
                        running <= 1'b0;
                    end else if (run_en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                end
                LOAD: begin
                    state   <= run_en ? RUN : STOP;
                    running <= run_en;
                end
                default: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Self-checking bench for rtc_time_ctrl: directed scenarios plus
// randomized traffic against a seconds-of-day reference model.
module tb_rtc_time_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       run_en;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       running;
    logic       day_pulse;
    logic       set_err;

    int total = 0;
    int bad   = 0;

    // reference model: time as seconds of day, mode 0=stop 1=run 2=load
    int m_t;
    int m_mode;
    bit m_prev;
    bit m_day;
    bit m_err;

    rtc_time_ctrl_if #(.SEC_W(6), .MIN_W(6), .HOUR_W(5)) sif ();

    rtc_time_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run_en    (run_en),
        .set_if    (sif),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .running   (running),
        .day_pulse (day_pulse),
        .set_err   (set_err)
    );

    always #5 clk = ~clk;

    function automatic int hms(int h, int m, int s);
        return h * 3600 + m * 60 + s;
    endfunction

    // advance the model with the inputs present before the edge,
    // then step the clock and settle
    task automatic cyc();
        bit rise;
        bit acc;
        bit ok;
        if (rst) begin
            m_t    = 0;
            m_mode = 0;
            m_prev = 1'b1;
            m_day  = 1'b0;
            m_err  = 1'b0;
        end else begin
            rise  = tick && !m_prev;
            acc   = sif.set_valid && (m_mode != 2);
            ok    = (sif.set_sec < 60) && (sif.set_min < 60)
                 && (sif.set_hour < 24);
            m_day = 1'b0;
            m_err = acc && !ok;
            if (acc && ok) begin
                m_t = hms(int'(sif.set_hour), int'(sif.set_min),
                          int'(sif.set_sec));
            end else if (!acc && m_mode == 1 && rise) begin
                m_t   = (m_t + 1) % 86400;
                m_day = (m_t == 0);
            end
            if (acc && ok) m_mode = 2;
            else m_mode = run_en ? 1 : 0;
            m_prev = tick;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic drive_load(int h, int m, int s);
        sif.set_valid = 1'b1;
        sif.set_hour  = 5'(h);
        sif.set_min   = 6'(m);
        sif.set_sec   = 6'(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick = 1'b1;
        run_en = 1'b0;
        sif.set_valid = 1'b0;
        sif.set_sec = '0;
        sif.set_min = '0;
        sif.set_hour = '0;
        cyc();
        cyc();
        total++;
        if ({hour, min, sec} !== 17'd0 || running !== 1'b0
            || day_pulse !== 1'b0 || set_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got %0d:%0d:%0d run=%b day=%b err=%b want 0:0:0 0 0 0",
                     hour, min, sec, running, day_pulse, set_err);
        end
        total++;
        if (sif.set_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got %b want 0", sif.set_ready);
        end
        rst = 1'b0;
        run_en = 1'b1;
        cyc();
        total++;
        if (running !== 1'b1 || sif.set_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_to_run run=%b rdy=%b want 1 1",
                     running, sif.set_ready);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if ({hour, min, sec} !== 17'd0) begin
                bad++;
                $display("FAIL held_tick got %0d:%0d:%0d want 0:0:0",
                         hour, min, sec);
            end
        end
    endtask

    task automatic test_tick();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b0;
            cyc();
            cyc();
            cyc();
            tick = 1'b1;
            cyc();
            total++;
            if (sec !== 6'(i + 1)) begin
                bad++;
                $display("FAIL tick_edge got %0d want %0d", sec, i + 1);
            end
        end
        tick = 1'b0;
        cyc();
        tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        total++;
        if (sec !== 6'd4) begin
            bad++;
            $display("FAIL tick_held got %0d want 4", sec);
        end
        tick = 1'b0;
        cyc();
    endtask

    task automatic test_wrap();
        drive_load(23, 59, 58);
        cyc();
        sif.set_valid = 1'b0;
        total++;
        if ({hour, min, sec} !== {5'd23, 6'd59, 6'd58}
            || sif.set_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_2359 got %0d:%0d:%0d rdy=%b want 23:59:58 0",
                     hour, min, sec, sif.set_ready);
        end
        cyc();
        pulse();
        total++;
        if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
            bad++;
            $display("FAIL pre_wrap got %0d:%0d:%0d want 23:59:59",
                     hour, min, sec);
        end
        tick = 1'b1;
        cyc();
        total++;
        if ({hour, min, sec} !== 17'd0 || day_pulse !== 1'b1) begin
            bad++;
            $display("FAIL day_wrap got %0d:%0d:%0d day=%b want 0:0:0 1",
                     hour, min, sec, day_pulse);
        end
        tick = 1'b0;
        cyc();
        total++;
        if (day_pulse !== 1'b0) begin
            bad++;
            $display("FAIL day_width got %b want 0", day_pulse);
        end
        drive_load(0, 59, 59);
        cyc();
        sif.set_valid = 1'b0;
        cyc();
        pulse();
        total++;
        if ({hour, min, sec} !== {5'd1, 6'd0, 6'd0}) begin
            bad++;
            $display("FAIL hour_carry got %0d:%0d:%0d want 1:0:0",
                     hour, min, sec);
        end
    endtask

    task automatic test_range();
        drive_load(12, 60, 0);
        cyc();
        total++;
        if (set_err !== 1'b1 || sif.set_ready !== 1'b1
            || {hour, min, sec} !== {5'd1, 6'd0, 6'd0}) begin
            bad++;
            $display("FAIL bad_load got err=%b rdy=%b %0d:%0d:%0d want 1 1 1:0:0",
                     set_err, sif.set_ready, hour, min, sec);
        end
        sif.set_valid = 1'b0;
        cyc();
        total++;
        if (set_err !== 1'b0) begin
            bad++;
            $display("FAIL err_width got %b want 0", set_err);
        end
        drive_load(12, 30, 0);
        cyc();
        sif.set_valid = 1'b0;
        total++;
        if (sif.set_ready !== 1'b0
            || {hour, min, sec} !== {5'd12, 6'd30, 6'd0}) begin
            bad++;
            $display("FAIL good_load rdy=%b %0d:%0d:%0d want 0 12:30:0",
                     sif.set_ready, hour, min, sec);
        end
        cyc();
        total++;
        if (sif.set_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_exit rdy=%b want 1", sif.set_ready);
        end
    endtask

    task automatic test_collide();
        tick = 1'b1;
        drive_load(5, 5, 5);
        cyc();
        sif.set_valid = 1'b0;
        tick = 1'b0;
        total++;
        if ({hour, min, sec} !== {5'd5, 6'd5, 6'd5}) begin
            bad++;
            $display("FAIL load_vs_tick got %0d:%0d:%0d want 5:5:5",
                     hour, min, sec);
        end
        cyc();
        drive_load(6, 6, 6);
        cyc();
        sif.set_valid = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        total++;
        if ({hour, min, sec} !== {5'd6, 6'd6, 6'd6}) begin
            bad++;
            $display("FAIL tick_in_load got %0d:%0d:%0d want 6:6:6",
                     hour, min, sec);
        end
    endtask

    task automatic test_hold_and_reset();
        drive_load(0, 0, 10);
        cyc();
        sif.set_valid = 1'b0;
        cyc();
        run_en = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) pulse();
        total++;
        if ({hour, min, sec} !== 17'd10 || running !== 1'b0) begin
            bad++;
            $display("FAIL hold got %0d:%0d:%0d run=%b want 0:0:10 0",
                     hour, min, sec, running);
        end
        run_en = 1'b1;
        cyc();
        pulse();
        total++;
        if ({hour, min, sec} !== 17'd11) begin
            bad++;
            $display("FAIL resume got %0d:%0d:%0d want 0:0:11",
                     hour, min, sec);
        end
        drive_load(1, 2, 3);
        cyc();
        sif.set_valid = 1'b0;
        rst = 1'b1;
        cyc();
        total++;
        if ({hour, min, sec} !== 17'd0 || running !== 1'b0
            || sif.set_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_load got %0d:%0d:%0d run=%b rdy=%b want 0:0:0 0 0",
                     hour, min, sec, running, sif.set_ready);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            tick          = $urandom_range(0, 1) == 1;
            run_en        = ($urandom_range(0, 9) != 0);
            sif.set_valid = ($urandom_range(0, 9) < 2);
            sif.set_sec   = 6'($urandom_range(0, 63));
            sif.set_min   = 6'($urandom_range(0, 63));
            sif.set_hour  = 5'($urandom_range(0, 31));
            cyc();
            total++;
            if (int'(sec) !== m_t % 60 || int'(min) !== (m_t / 60) % 60
                || int'(hour) !== m_t / 3600) begin
                bad++;
                $display("FAIL rnd_time cyc=%0d got %0d:%0d:%0d want %0d",
                         i, hour, min, sec, m_t);
            end
            total++;
            if (running !== (m_mode == 1)) begin
                bad++;
                $display("FAIL rnd_running cyc=%0d got %b want %b",
                         i, running, m_mode == 1);
            end
            total++;
            if (sif.set_ready !== (!rst && m_mode != 2)) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d got %b want %b",
                         i, sif.set_ready, !rst && m_mode != 2);
            end
            total++;
            if (day_pulse !== m_day || set_err !== m_err) begin
                bad++;
                $display("FAIL rnd_pulse cyc=%0d day=%b err=%b want %b %b",
                         i, day_pulse, set_err, m_day, m_err);
            end
        end
        rst = 1'b0;
        sif.set_valid = 1'b0;
        cyc();
    endtask

    initial begin
        m_t = 0;
        m_mode = 0;
        m_prev = 1'b1;
        m_day = 1'b0;
        m_err = 1'b0;
        test_reset();
        test_tick();
        test_wrap();
        test_range();
        test_collide();
        test_hold_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
